// File: rtl/mp_add_pkg.sv
// Shared types for the byte-serial multi-precision adder.
// Optional subtract support is enabled with MP_ADD_SUB_EN (see mp_add_sequencer).
package mp_add_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/adder8_slice.sv
// Combinational 8-bit ripple-carry adder slice, shared by every byte of an operation.
module adder8_slice
    import mp_add_pkg::*;
(
    input  logic [BYTE_W-1:0] a,
    input  logic [BYTE_W-1:0] b,
    input  logic              cin,
    output logic [BYTE_W-1:0] sum,
    output logic              cout
);

    always_comb begin : ripple
        logic [BYTE_W:0] c;
        c    = '0;
        sum  = '0;
        c[0] = cin;
        for (int i = 0; i < BYTE_W; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        cout = c[BYTE_W];
    end

endmodule

// File: rtl/mp_add_sequencer.sv
// Byte-serial multi-precision adder: one adder8_slice walked LSB-first over NBYTES bytes.
// Define MP_ADD_SUB_EN to add the op_sub input (A-B) and the out_ovf signed-overflow output.
module mp_add_sequencer
    import mp_add_pkg::*;
#(
    parameter  int NBYTES = 4,
    localparam int CNT_W  = $clog2(NBYTES) + 1,
    localparam int W      = 8 * NBYTES
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] op_a,
    input  logic [W-1:0] op_b,
    input  logic         op_cin,
`ifdef MP_ADD_SUB_EN
    input  logic         op_sub,
    output logic         out_ovf,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] result,
    output logic         out_cout,
    output logic         busy,
    output logic [1:0]   dbg_state_o
);

    // Handshake: a transfer happens on a rising edge where valid && ready are both high;
    // valid is held with its data stable until that edge, and ready never gates valid.

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               carry_q;
    logic [W-1:0]       a_q, b_q, result_q;
    logic               cout_q, in_ready_q, out_valid_q, busy_q;

    logic [BYTE_W-1:0]  slice_a, slice_b, slice_sum;
    logic               slice_cout, carry_d, last_byte;

`ifdef MP_ADD_SUB_EN
    logic               sub_q, ovf_q, ovf_d;
`endif

    always_comb begin
        slice_a   = a_q[BYTE_W*int'(cnt_q) +: BYTE_W];
        slice_b   = b_q[BYTE_W*int'(cnt_q) +: BYTE_W];
        carry_d   = op_cin;
        last_byte = (cnt_q == CNT_W'(NBYTES - 1));
`ifdef MP_ADD_SUB_EN
        // Subtract as A + ~B + 1: invert B into the slice and force the initial carry.
        if (sub_q) slice_b = ~slice_b;
        if (op_sub) carry_d = 1'b1;
        ovf_d = (slice_a[BYTE_W-1] == slice_b[BYTE_W-1]) &&
                (slice_sum[BYTE_W-1] != slice_a[BYTE_W-1]);
`endif
    end

    adder8_slice u_slice (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (carry_q),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            result_q    <= '0;
            cout_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef MP_ADD_SUB_EN
            sub_q       <= 1'b0;
            ovf_q       <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        a_q        <= op_a;
                        b_q        <= op_b;
                        carry_q    <= carry_d;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= RUN;
`ifdef MP_ADD_SUB_EN
                        sub_q      <= op_sub;
`endif
                    end
                end
                RUN: begin
                    result_q[BYTE_W*int'(cnt_q) +: BYTE_W] <= slice_sum;
                    carry_q <= slice_cout;
                    cnt_q   <= cnt_q + CNT_W'(1);
                    if (last_byte) begin
                        cout_q      <= slice_cout;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
`ifdef MP_ADD_SUB_EN
                        ovf_q       <= ovf_d;
`endif
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign result      = result_q;
    assign out_cout    = cout_q;
    assign busy        = busy_q;
    assign dbg_state_o = state_q;
`ifdef MP_ADD_SUB_EN
    assign out_ovf     = ovf_q;
`endif

endmodule

// File: tb/tb_mp_add_sequencer.sv
// Self-checking bench for mp_add_sequencer: directed cases, reset abort, back-to-back and random ops.
module tb_mp_add_sequencer;
  localparam int NBYTES = 4;
  localparam int W = 8 * NBYTES;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic op_cin = 1'b0;
  logic out_valid;
  logic out_ready = 1'b0;
  logic [W-1:0] result;
  logic out_cout;
  logic busy;
  logic [1:0] dbg_state;
`ifdef MP_ADD_SUB_EN
  logic op_sub = 1'b0;
  logic out_ovf;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int hs_cyc = 0;
  logic [W+1:0] exp_q[$];
  logic [W+1:0] mon_e;

  mp_add_sequencer #(.NBYTES(NBYTES)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .op_a(op_a),
    .op_b(op_b),
    .op_cin(op_cin),
`ifdef MP_ADD_SUB_EN
    .op_sub(op_sub),
    .out_ovf(out_ovf),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result(result),
    .out_cout(out_cout),
    .busy(busy),
    .dbg_state_o(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // reference: {ovf, cout, sum} of A + (sub ? ~B : B) + (sub ? 1 : cin)
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic cin, input logic sub);
    logic [W:0] s;
    logic [W-1:0] bb;
    logic c;
    logic ovf;
    bb = sub ? ~b : b;
    c = sub ? 1'b1 : cin;
    s = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, c};
    ovf = (a[W-1] == bb[W-1]) && (s[W-1] != a[W-1]);
    return {ovf, s};
  endfunction

  // driver: present an operand set now, hold until accepted, push expectation
  task automatic send_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                         input logic sub);
    int t;
    op_a = a;
    op_b = b;
    op_cin = cin;
`ifdef MP_ADD_SUB_EN
    op_sub = sub;
`endif
    in_valid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      check_val("accept_timeout", 64'(in_ready), 64'(1));
      in_valid = 1'b0;
      return;
    end
    acc_cyc = cyc;
    exp_q.push_back(model(a, b, cin, sub));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    // operands are scrambled after accept; the latched copy must be used
    op_a = $urandom;
    op_b = $urandom;
    op_cin = $urandom_range(0, 1);
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (n < 50) begin
      @(negedge clk);
      n++;
      if (out_valid) break;
    end
    if (!out_valid) check_val("out_timeout", 64'(out_valid), 64'(1));
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() > 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    check_val("drain_empty", 64'(exp_q.size()), 64'(0));
  endtask

  // scoreboard: compare on every output handshake
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      hs_cyc = cyc;
      if (exp_q.size() == 0) begin
        check_val("unexpected_out", 64'(result), 64'(0));
      end else begin
        mon_e = exp_q.pop_front();
        check_val("result", 64'(result), 64'(mon_e[W-1:0]));
        check_val("cout", 64'(out_cout), 64'(mon_e[W]));
`ifdef MP_ADD_SUB_EN
        check_val("ovf", 64'(out_ovf), 64'(mon_e[W+1]));
`endif
      end
    end
  end

  initial begin : main
    int lat;
    logic [W+1:0] e;
    logic seen;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_in_ready", 64'(in_ready), 64'(1));
    check_val("rst_out_valid", 64'(out_valid), 64'(0));
    check_val("rst_busy", 64'(busy), 64'(0));
    check_val("rst_result", 64'(result), 64'(0));
    check_val("rst_cout", 64'(out_cout), 64'(0));
    check_val("rst_state", 64'(dbg_state), 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;

    // 1) basic add and latency
    send_op(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
    check_val("run_busy", 64'(busy), 64'(1));
    check_val("run_in_ready", 64'(in_ready), 64'(0));
    check_val("run_state", 64'(dbg_state), 64'(1));
    wait_out(lat);
    check_val("latency", 64'(lat), 64'(NBYTES + 1));
    check_val("t1_value", 64'(result), 64'(32'h2345_6789));

    // 2) full carry ripple
    send_op(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0);
    wait_out(lat);
    check_val("t2_value", 64'(result), 64'(32'h0000_0000));
    check_val("t2_cout", 64'(out_cout), 64'(1));

    // 3) back-pressure in DONE
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    send_op(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b1, 1'b0);
    e = model(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b1, 1'b0);
    wait_out(lat);
    for (int i = 0; i < 10; i++) begin
      check_val("hold_valid", 64'(out_valid), 64'(1));
      check_val("hold_result", 64'(result), 64'(e[W-1:0]));
      check_val("hold_in_ready", 64'(in_ready), 64'(0));
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    drain();

    // 4) reset during the second RUN cycle aborts the op
    @(posedge clk);
    #1;
    send_op(32'hCAFE_0001, 32'h0000_FFFF, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    void'(exp_q.pop_back());
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_val("abort_in_ready", 64'(in_ready), 64'(1));
    check_val("abort_out_valid", 64'(out_valid), 64'(0));
    check_val("abort_busy", 64'(busy), 64'(0));
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      seen = seen | out_valid;
    end
    check_val("abort_no_out", 64'(seen), 64'(0));
    send_op(32'h0F0F_0F0F, 32'hF0F0_F0F1, 1'b0, 1'b0);
    wait_out(lat);
    check_val("post_abort_value", 64'(result), 64'(32'h0000_0000));
    check_val("post_abort_cout", 64'(out_cout), 64'(1));

    // 5) back-to-back: second op is offered during DONE
    @(posedge clk);
    #1;
    send_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0);
    wait_out(lat);
    send_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b1, 1'b0);
    check_val("b2b_accept_gap", 64'(acc_cyc - hs_cyc), 64'(1));
    wait_out(lat);
    check_val("b2b_value", 64'(result), 64'(32'h8000_0001));

`ifdef MP_ADD_SUB_EN
    // 6) subtract with signed overflow
    @(posedge clk);
    #1;
    send_op(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1);
    wait_out(lat);
    check_val("sub_value", 64'(result), 64'(32'h7FFF_FFFF));
    check_val("sub_ovf", 64'(out_ovf), 64'(1));
    check_val("sub_cout", 64'(out_cout), 64'(1));
`endif

    // random ops with random back-pressure
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      out_ready = 1'b1;
`ifdef MP_ADD_SUB_EN
      send_op($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
`else
      send_op($urandom, $urandom, 1'($urandom_range(0, 1)), 1'b0);
`endif
      out_ready = 1'($urandom_range(0, 1));
      repeat ($urandom_range(1, 7)) @(posedge clk);
      #1;
      out_ready = 1'b1;
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
